// File: rtl/ebreak_halt_ctrl.sv
// ebreak_halt_ctrl: end-of-simulation sequencer for the NPC core.
//   Watches the commit stream for EBREAK. When one retires, the block raises
//   halt_req, lets the pipeline drain for DRAIN_CYCLES, then raises sim_done.
//   At the EBREAK it latches the exit code (a0) and the halt PC. A watchdog
//   ends runs that stop committing.
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   commit_valid            one instruction retires this cycle
//   commit_inst, commit_pc  encoding and PC of the retiring instruction
//   a0_value                current x10, sampled in the EBREAK commit cycle
//   halt_req                fetch/issue stall, high in DRAIN and DONE
//   sim_done                sticky end-of-simulation flag, high only in DONE
//   timed_out               sticky, the watchdog ended the run
//   good_trap               clean exit: done, not timed out, exit code 0
//   exit_code, halt_pc      a0 and PC captured at EBREAK (or on timeout)
//   cycle_cnt, instret_cnt  RUN cycles and RUN commits, EBREAK included
module ebreak_halt_ctrl #(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned DRAIN_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TO_W           = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            commit_valid,
  input  logic [31:0]     commit_inst,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [XLEN-1:0] a0_value,
  output logic            halt_req,
  output logic            sim_done,
  output logic            timed_out,
  output logic            good_trap,
  output logic [XLEN-1:0] exit_code,
  output logic [XLEN-1:0] halt_pc,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instret_cnt
);

  localparam logic [31:0] EbreakInst = 32'h0010_0073;
  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DrainLast =
      DW'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
  localparam logic [TO_W-1:0] WdLast =
      TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic [XLEN-1:0]   cycle_q, cycle_d;
  logic [XLEN-1:0]   instret_q, instret_d;
  logic [XLEN-1:0]   exit_q, exit_d;
  logic [XLEN-1:0]   halt_pc_q, halt_pc_d;
  logic [XLEN-1:0]   last_pc_q, last_pc_d;
  logic              timed_q, timed_d;

  logic is_ebreak;
  logic wd_expire;

  assign is_ebreak = commit_valid && (commit_inst == EbreakInst);
  // A commit clears the watchdog, so expiry only fires on an idle cycle.
  assign wd_expire = (TIMEOUT_CYCLES != 0) && !commit_valid && (wd_q == WdLast);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (is_ebreak) begin
          state_d = (DRAIN_CYCLES == 0) ? StDone : StDrain;
        end else if (wd_expire) begin
          state_d = StDone;
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) state_d = StDone;
      end
      StDone:  state_d = StDone;
      default: state_d = StRun;
    endcase
  end

  // Outputs, all derived from registered state
  always_comb begin
    halt_req    = (state_q != StRun);
    sim_done    = (state_q == StDone);
    timed_out   = timed_q;
    good_trap   = (state_q == StDone) && !timed_q && (exit_q == '0);
    exit_code   = exit_q;
    halt_pc     = halt_pc_q;
    cycle_cnt   = cycle_q;
    instret_cnt = instret_q;
  end

  // Datapath next-state: only RUN updates counters and latches
  always_comb begin
    drain_d   = drain_q;
    wd_d      = wd_q;
    cycle_d   = cycle_q;
    instret_d = instret_q;
    exit_d    = exit_q;
    halt_pc_d = halt_pc_q;
    last_pc_d = last_pc_q;
    timed_d   = timed_q;
    if (state_q == StRun) begin
      cycle_d = cycle_q + XLEN'(1);
      if (commit_valid) begin
        instret_d = instret_q + XLEN'(1);
        wd_d      = '0;
        last_pc_d = commit_pc;
      end else if (wd_q != '1) begin
        wd_d = wd_q + TO_W'(1);
      end
      if (is_ebreak) begin
        exit_d    = a0_value;
        halt_pc_d = commit_pc;
      end else if (wd_expire) begin
        timed_d   = 1'b1;
        exit_d    = '1;
        halt_pc_d = last_pc_q;
      end
    end else if (state_q == StDrain) begin
      drain_d = drain_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_q   <= '0;
      wd_q      <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
      exit_q    <= '0;
      halt_pc_q <= '0;
      last_pc_q <= '0;
      timed_q   <= 1'b0;
    end else begin
      drain_q   <= drain_d;
      wd_q      <= wd_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      exit_q    <= exit_d;
      halt_pc_q <= halt_pc_d;
      last_pc_q <= last_pc_d;
      timed_q   <= timed_d;
    end
  end

endmodule

// File: tb/tb_ebreak_halt_ctrl.sv
module tb_ebreak_halt_ctrl;

  localparam logic [31:0] Ebreak = 32'h0010_0073;
  localparam logic [31:0] Nop    = 32'h0000_0013;
  localparam logic [63:0] Base   = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_inst = '0;
  logic [63:0] commit_pc = '0;
  logic [63:0] a0_value = '0;

  logic        halt_req, sim_done, timed_out, good_trap;
  logic [63:0] exit_code, halt_pc, cycle_cnt, instret_cnt;
  logic        z_halt_req, z_sim_done, z_timed_out, z_good_trap;
  logic [63:0] z_exit_code, z_halt_pc, z_cycle_cnt, z_instret_cnt;

  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  // Main instance: 4 drain cycles, short watchdog
  ebreak_halt_ctrl #(
    .XLEN(64), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(16), .TO_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_inst(commit_inst),
    .commit_pc(commit_pc), .a0_value(a0_value), .halt_req(halt_req), .sim_done(sim_done),
    .timed_out(timed_out), .good_trap(good_trap), .exit_code(exit_code), .halt_pc(halt_pc),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  // Second instance: no drain, watchdog off
  ebreak_halt_ctrl #(
    .XLEN(64), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(0), .TO_W(32)
  ) dut_z (
    .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_inst(commit_inst),
    .commit_pc(commit_pc), .a0_value(a0_value), .halt_req(z_halt_req),
    .sim_done(z_sim_done), .timed_out(z_timed_out), .good_trap(z_good_trap),
    .exit_code(z_exit_code), .halt_pc(z_halt_pc), .cycle_cnt(z_cycle_cnt),
    .instret_cnt(z_instret_cnt)
  );

  typedef struct {
    logic        cv;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] a0;
    logic        halt;
    logic        done;
    logic        good;
    logic [63:0] exit_c;
    logic [63:0] hpc;
    logic [63:0] instret;
    logic [63:0] cyc;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1ns after the rising edge
  task automatic step(input logic cv, input logic [31:0] inst, input logic [63:0] pc,
                      input logic [63:0] a0);
    commit_valid = cv;
    commit_inst  = inst;
    commit_pc    = pc;
    a0_value     = a0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    commit_valid = 1'b0;
    commit_inst  = '0;
    commit_pc    = '0;
    a0_value     = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].cv, tbl[i].inst, tbl[i].pc, tbl[i].a0);
      chk($sformatf("%s row%0d halt_req", tag, i), 64'(halt_req), 64'(tbl[i].halt));
      chk($sformatf("%s row%0d sim_done", tag, i), 64'(sim_done), 64'(tbl[i].done));
      chk($sformatf("%s row%0d good_trap", tag, i), 64'(good_trap), 64'(tbl[i].good));
      chk($sformatf("%s row%0d exit_code", tag, i), exit_code, tbl[i].exit_c);
      chk($sformatf("%s row%0d halt_pc", tag, i), halt_pc, tbl[i].hpc);
      chk($sformatf("%s row%0d instret", tag, i), instret_cnt, tbl[i].instret);
      chk($sformatf("%s row%0d cycle_cnt", tag, i), cycle_cnt, tbl[i].cyc);
      if (i == 10) begin
        // Zero-drain instance goes straight to DONE after the EBREAK edge
        chk($sformatf("%s z halt_req", tag), 64'(z_halt_req), 64'd1);
        chk($sformatf("%s z sim_done", tag), 64'(z_sim_done), 64'd1);
        chk($sformatf("%s z good_trap", tag), 64'(z_good_trap), 64'd1);
        chk($sformatf("%s z halt_pc", tag), z_halt_pc, Base + 64'h28);
      end
      if (i == 9) begin
        chk($sformatf("%s z pre-ebreak done", tag), 64'(z_sim_done), 64'd0);
      end
    end
  endtask

  initial begin
    // Scenario 1 table: 10 commits, EBREAK at pc 0x8000_0028 with a0=0, idle drain
    for (int i = 0; i < 10; i++) begin
      tbl[i] = '{cv: 1'b1, inst: Nop, pc: Base + 64'(4 * i), a0: 64'(i + 1),
                 halt: 1'b0, done: 1'b0, good: 1'b0, exit_c: 64'd0, hpc: 64'd0,
                 instret: 64'(i + 1), cyc: 64'(i + 1)};
    end
    tbl[10] = '{cv: 1'b1, inst: Ebreak, pc: Base + 64'h28, a0: 64'd0,
                halt: 1'b1, done: 1'b0, good: 1'b0, exit_c: 64'd0, hpc: Base + 64'h28,
                instret: 64'd11, cyc: 64'd11};
    for (int i = 11; i < 16; i++) begin
      tbl[i] = '{cv: 1'b0, inst: 32'h0, pc: 64'h0, a0: 64'h99,
                 halt: 1'b1, done: (i >= 14), good: (i >= 14), exit_c: 64'd0,
                 hpc: Base + 64'h28, instret: 64'd11, cyc: 64'd11};
    end

    // Reset state
    #2;
    chk("reset halt_req", 64'(halt_req), 64'd0);
    chk("reset sim_done", 64'(sim_done), 64'd0);
    chk("reset exit_code", exit_code, 64'd0);
    chk("reset cycle_cnt", cycle_cnt, 64'd0);
    do_reset();
    run_table("s1");

    // Scenario 2: non-zero exit code
    do_reset();
    step(1'b1, Ebreak, Base + 64'h100, 64'h2A);
    repeat (4) step(1'b0, 32'h0, 64'h0, 64'h0);
    chk("s2 sim_done", 64'(sim_done), 64'd1);
    chk("s2 good_trap", 64'(good_trap), 64'd0);
    chk("s2 exit_code", exit_code, 64'h2A);
    chk("s2 timed_out", 64'(timed_out), 64'd0);
    chk("s2 instret", instret_cnt, 64'd1);
    chk("s2 z good_trap", 64'(z_good_trap), 64'd0);

    // Scenario 3: one commit, then silence; EBREAK encoding without valid is ignored
    do_reset();
    step(1'b1, Nop, Base, 64'h55);
    repeat (15) step(1'b0, Ebreak, 64'h1234, 64'h0);
    chk("s3 done before expiry", 64'(sim_done), 64'd0);
    chk("s3 halt before expiry", 64'(halt_req), 64'd0);
    step(1'b0, Ebreak, 64'h1234, 64'h0);
    chk("s3 sim_done", 64'(sim_done), 64'd1);
    chk("s3 timed_out", 64'(timed_out), 64'd1);
    chk("s3 exit_code", exit_code, {64{1'b1}});
    chk("s3 halt_pc", halt_pc, Base);
    chk("s3 good_trap", 64'(good_trap), 64'd0);
    chk("s3 instret", instret_cnt, 64'd1);
    chk("s3 cycle_cnt", cycle_cnt, 64'd17);
    chk("s3 z no timeout", 64'(z_timed_out), 64'd0);
    chk("s3 z not done", 64'(z_sim_done), 64'd0);

    // Scenario 4: commits and a second EBREAK during DRAIN, then inputs in DONE
    do_reset();
    step(1'b1, Ebreak, Base + 64'h40, 64'h7);
    step(1'b1, Nop, Base + 64'h44, 64'h1);
    step(1'b1, Ebreak, Base + 64'h50, 64'h5);
    step(1'b1, Nop, Base + 64'h54, 64'h2);
    chk("s4 drain not done", 64'(sim_done), 64'd0);
    step(1'b1, Nop, Base + 64'h58, 64'h3);
    chk("s4 sim_done", 64'(sim_done), 64'd1);
    chk("s4 exit_code", exit_code, 64'h7);
    chk("s4 halt_pc", halt_pc, Base + 64'h40);
    chk("s4 instret", instret_cnt, 64'd1);
    step(1'b1, Ebreak, Base + 64'h60, 64'h0);
    step(1'b0, 32'h0, 64'h0, 64'h0);
    chk("s4 done frozen exit", exit_code, 64'h7);
    chk("s4 done frozen cycle", cycle_cnt, 64'd1);
    chk("s4 done sticky", 64'(sim_done), 64'd1);

    // Scenario 5: asynchronous reset two cycles into DRAIN
    do_reset();
    step(1'b1, Ebreak, Base + 64'h80, 64'h9);
    step(1'b0, 32'h0, 64'h0, 64'h0);
    step(1'b0, 32'h0, 64'h0, 64'h0);
    chk("s5 in drain", 64'(halt_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("s5 async halt_req", 64'(halt_req), 64'd0);
    chk("s5 async exit_code", exit_code, 64'd0);
    chk("s5 async halt_pc", halt_pc, 64'd0);
    chk("s5 async instret", instret_cnt, 64'd0);
    chk("s5 async cycle_cnt", cycle_cnt, 64'd0);
    do_reset();
    run_table("s5");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
